// File: rtl/pipe_seg_adder.sv
// pipe_seg_adder: pipelined segmented ripple-carry adder/subtractor. One SEG-bit
// segment is resolved per stage with a registered inter-stage carry and a global-stall handshake.
module pipe_seg_adder #(
  parameter int WIDTH = 34,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES  = (WIDTH + SEG - 1) / SEG;
  localparam int LAST_LO = (STAGES - 1) * SEG;
  localparam int LAST_W  = WIDTH - LAST_LO;

  logic             w_adv;
  logic             w_accept;
  logic             w_cin0;
  logic [WIDTH-1:0] w_b_eff;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic             r_ovf;

  assign w_adv    = !r_out_vld || out_ready;
  // NOTE: in_ready is forced high during rst so upstream sees a clean restart; the rst branch still blocks the accept.
  assign in_ready = w_adv || rst;
  assign w_accept = in_valid && w_adv;
  assign w_b_eff  = sub ? ~b : b;
  assign w_cin0   = sub | c_in;

  // Full-width stages 0..STAGES-2: resolve one segment, skew the untouched upper operand bits.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int UPW = WIDTH - LO - SEG;

    logic [SEG-1:0]    w_x;
    logic [SEG-1:0]    w_y;
    logic              w_cin;
    logic              w_vin;
    logic [SEG:0]      w_seg;
    logic [LO+SEG-1:0] w_lo_next;
    logic [UPW-1:0]    w_a_up_next;
    logic [UPW-1:0]    w_b_up_next;

    logic              r_vld;
    logic              r_cy;
    logic [LO+SEG-1:0] r_lo;
    logic [UPW-1:0]    r_a_up;
    logic [UPW-1:0]    r_b_up;

    if (k == 0) begin : g_head
      assign w_x         = a[SEG-1:0];
      assign w_y         = w_b_eff[SEG-1:0];
      assign w_cin       = w_cin0;
      assign w_vin       = w_accept;
      assign w_a_up_next = a[WIDTH-1:SEG];
      assign w_b_up_next = w_b_eff[WIDTH-1:SEG];
      assign w_lo_next   = w_seg[SEG-1:0];
    end else begin : g_body
      assign w_x         = g_stage[k-1].r_a_up[SEG-1:0];
      assign w_y         = g_stage[k-1].r_b_up[SEG-1:0];
      assign w_cin       = g_stage[k-1].r_cy;
      assign w_vin       = g_stage[k-1].r_vld;
      assign w_a_up_next = g_stage[k-1].r_a_up[UPW+SEG-1:SEG];
      assign w_b_up_next = g_stage[k-1].r_b_up[UPW+SEG-1:SEG];
      assign w_lo_next   = {w_seg[SEG-1:0], g_stage[k-1].r_lo};
    end

    assign w_seg = {1'b0, w_x} + {1'b0, w_y} + {{SEG{1'b0}}, w_cin};

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_cy   <= 1'b0;
        r_lo   <= '0;
        r_a_up <= '0;
        r_b_up <= '0;
      end else if (w_adv) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_cy   <= w_seg[SEG];
          r_lo   <= w_lo_next;
          r_a_up <= w_a_up_next;
          r_b_up <= w_b_up_next;
        end
      end
    end
  end

  // Output stage: last (possibly partial) segment, carry and overflow taken from bit WIDTH-1.
  logic [LAST_W-1:0] w_lx;
  logic [LAST_W-1:0] w_ly;
  logic              w_lcin;
  logic              w_lvin;
  logic [LAST_W:0]   w_lseg;
  logic [WIDTH-1:0]  w_s_next;
  logic              w_cmsb;

  if (STAGES == 1) begin : g_single
    assign w_lx     = a;
    assign w_ly     = w_b_eff;
    assign w_lcin   = w_cin0;
    assign w_lvin   = w_accept;
    assign w_s_next = w_lseg[LAST_W-1:0];
  end else begin : g_tail
    assign w_lx     = g_stage[STAGES-2].r_a_up;
    assign w_ly     = g_stage[STAGES-2].r_b_up;
    assign w_lcin   = g_stage[STAGES-2].r_cy;
    assign w_lvin   = g_stage[STAGES-2].r_vld;
    assign w_s_next = {w_lseg[LAST_W-1:0], g_stage[STAGES-2].r_lo};
  end

  assign w_lseg = {1'b0, w_lx} + {1'b0, w_ly} + {{LAST_W{1'b0}}, w_lcin};
  assign w_cmsb = w_lseg[LAST_W-1] ^ w_lx[LAST_W-1] ^ w_ly[LAST_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_s       <= '0;
      r_c_out   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= w_lvin;
      if (w_lvin) begin
        r_s     <= w_s_next;
        r_c_out <= w_lseg[LAST_W];
        r_ovf   <= w_cmsb ^ w_lseg[LAST_W];
      end
    end
  end

  assign out_valid = r_out_vld;
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Directed bench for pipe_seg_adder: three configurations (34/8, 16/16, 17/4),
// hand-computed vectors, back-to-back and stall/reset sequences against a scoreboard.
module tb_pipe_seg_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        t_valid;
  logic        t_ci;
  logic        t_sub;
  logic        out_ready;
  logic [33:0] t_a;
  logic [33:0] t_b;
  int          sel;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic        c0, c1, c2;
  logic        v0, v1, v2;
  logic [33:0] s0;
  logic [15:0] s1;
  logic [16:0] s2;

  logic        o_rdy, o_valid, o_c, o_ovf;
  logic [33:0] o_s;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [35:0] sbq[$];

  pipe_seg_adder #(.WIDTH(34), .SEG(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(t_valid && sel == 0), .in_ready(rdy0),
    .a(t_a), .b(t_b), .c_in(t_ci), .sub(t_sub),
    .out_valid(vld0), .out_ready(out_ready), .s(s0), .c_out(c0), .ovf(v0)
  );

  pipe_seg_adder #(.WIDTH(16), .SEG(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(t_valid && sel == 1), .in_ready(rdy1),
    .a(t_a[15:0]), .b(t_b[15:0]), .c_in(t_ci), .sub(t_sub),
    .out_valid(vld1), .out_ready(out_ready), .s(s1), .c_out(c1), .ovf(v1)
  );

  pipe_seg_adder #(.WIDTH(17), .SEG(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(t_valid && sel == 2), .in_ready(rdy2),
    .a(t_a[16:0]), .b(t_b[16:0]), .c_in(t_ci), .sub(t_sub),
    .out_valid(vld2), .out_ready(out_ready), .s(s2), .c_out(c2), .ovf(v2)
  );

  always_comb begin
    o_rdy = rdy0; o_valid = vld0; o_s = s0; o_c = c0; o_ovf = v0;
    if (sel == 1) begin
      o_rdy = rdy1; o_valid = vld1; o_s = {18'd0, s1}; o_c = c1; o_ovf = v1;
    end else if (sel == 2) begin
      o_rdy = rdy2; o_valid = vld2; o_s = {17'd0, s2}; o_c = c2; o_ovf = v2;
    end
  end

  function automatic int cur_width();
    return (sel == 1) ? 16 : (sel == 2) ? 17 : 34;
  endfunction

  function automatic int cur_lat();
    return (sel == 1) ? 1 : 5;
  endfunction

  // Reference: {ovf, c_out, s}; overflow from operand/result sign agreement.
  function automatic logic [35:0] model(int w, logic [33:0] x, logic [33:0] y, logic ci, logic sb);
    logic [34:0] mask, xm, bx, t;
    logic        cin, ov;
    mask = (35'd1 << w) - 35'd1;
    xm   = {1'b0, x} & mask;
    bx   = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
    cin  = sb ? 1'b1 : ci;
    t    = xm + bx + {34'd0, cin};
    ov   = (xm[w-1] == bx[w-1]) && (t[w-1] != xm[w-1]);
    return {ov, t[w], t[33:0] & mask[33:0]};
  endfunction

  function automatic logic [33:0] rnd34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[33:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single op on an idle pipeline: latency, result, then hold while out_valid=0.
  task automatic run_op(input string tag, input logic [33:0] xa, input logic [33:0] xb,
                        input logic ci, input logic sb,
                        input logic [33:0] es, input logic ec, input logic eo);
    int n;
    bit seen;
    @(negedge clk);
    t_a = xa; t_b = xb; t_ci = ci; t_sub = sb; t_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 64'(o_rdy), 64'(1));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      t_valid = 1'b0;
      n++;
      #1 if (o_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(n), 64'(cur_lat()));
    check({tag, "_s"}, 64'(o_s), 64'(es));
    check({tag, "_c"}, 64'(o_c), 64'(ec));
    check({tag, "_ovf"}, 64'(o_ovf), 64'(eo));
    @(negedge clk);
    #1;
    check({tag, "_gone"}, 64'(o_valid), 64'(0));
    check({tag, "_hold"}, 64'(o_s), 64'(es));
  endtask

  // One cycle of handshake traffic with scoreboard checking.
  task automatic step(input logic iv, input logic [33:0] xa, input logic [33:0] xb,
                      input logic ci, input logic sb, input logic ordy);
    @(negedge clk);
    t_valid = iv; t_a = xa; t_b = xb; t_ci = ci; t_sub = sb; out_ready = ordy;
    #1;
    if (o_valid) begin
      if (sbq.size() == 0) begin
        check("stale", 64'(o_valid), 64'(0));
      end else begin
        check("sb_res", 64'({o_ovf, o_c, o_s}), 64'(sbq[0]));
        if (ordy) begin
          void'(sbq.pop_front());
          n_pop++;
        end
      end
    end
    if (iv && o_rdy) sbq.push_back(model(cur_width(), xa, xb, ci, sb));
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 60 && sbq.size() > 0; g++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check(tag, 64'(sbq.size()), 64'(0));
  endtask

  logic [33:0] ta_q[10];
  logic [33:0] tb_q[10];
  logic        ci_q[10];
  logic        sb_q[10];

  initial begin
    rst = 1'b1; t_valid = 1'b0; t_a = '0; t_b = '0; t_ci = 1'b0; t_sub = 1'b0;
    out_ready = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_vld", 64'(o_valid), 64'(0));
    check("rst_s", 64'(o_s), 64'(0));
    check("rst_c", 64'(o_c), 64'(0));
    check("rst_ovf", 64'(o_ovf), 64'(0));
    check("rst_rdy", 64'(o_rdy), 64'(1));
    check("rst_vld1", 64'(vld1), 64'(0));
    check("rst_vld2", 64'(vld2), 64'(0));

    // 34-bit, SEG=8: full carry ripple, subtraction, signed overflow.
    run_op("w34_ripple", 34'h3_FFFF_FFFF, 34'd1, 1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
    run_op("w34_sub_neg", 34'd5, 34'd7, 1'b0, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b0);
    run_op("w34_sub_pos", 34'd7, 34'd5, 1'b0, 1'b1, 34'h2, 1'b1, 1'b0);
    run_op("w34_ovf_pos", 34'h1_FFFF_FFFF, 34'd1, 1'b0, 1'b0, 34'h2_0000_0000, 1'b0, 1'b1);
    run_op("w34_ovf_neg", 34'h2_0000_0000, 34'h2_0000_0000, 1'b0, 1'b0, 34'h0, 1'b1, 1'b1);
    run_op("w34_cin", 34'hFF, 34'd0, 1'b1, 1'b0, 34'h100, 1'b0, 1'b0);
    run_op("w34_sub_cin", 34'd10, 34'd3, 1'b1, 1'b1, 34'd7, 1'b1, 1'b0);

    // Ten back-to-back ops: results appear on ten consecutive cycles, in order.
    for (int i = 0; i < 10; i++) begin
      ta_q[i] = rnd34(); tb_q[i] = rnd34();
      ci_q[i] = i[0];    sb_q[i] = i[1];
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (i < 10) begin
        t_valid = 1'b1; t_a = ta_q[i]; t_b = tb_q[i]; t_ci = ci_q[i]; t_sub = sb_q[i];
      end else begin
        t_valid = 1'b0;
      end
      #1;
      check("b2b_vld", 64'(o_valid), 64'(i >= 5 && i < 15));
      if (i >= 5 && i < 15)
        check("b2b_res", 64'({o_ovf, o_c, o_s}),
              64'(model(34, ta_q[i-5], tb_q[i-5], ci_q[i-5], sb_q[i-5])));
    end

    // Stall for 3 cycles with a result pending: in_ready low, output held, nothing lost.
    sbq.delete();
    n_pop = 0;
    for (int i = 0; i < 5; i++) step(1'b1, rnd34(), rnd34(), 1'b0, 1'(i % 2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rnd34(), rnd34(), 1'b1, 1'b0, 1'b0);
      check("stall_vld", 64'(o_valid), 64'(1));
      check("stall_rdy", 64'(o_rdy), 64'(0));
    end
    drain("stall_drain");
    check("stall_cnt", 64'(n_pop), 64'(5));
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), rnd34(), rnd34(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain("rand_drain");

    // Reset mid-stall with three ops in flight.
    sbq.delete();
    for (int i = 0; i < 3; i++) step(1'b1, rnd34(), rnd34(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("rst2_pre_vld", 64'(o_valid), 64'(1));
    @(negedge clk);
    rst = 1'b1; t_valid = 1'b1; t_a = 34'd1; t_b = 34'd1;
    #1 check("rst2_rdy", 64'(o_rdy), 64'(1));
    @(negedge clk);
    rst = 1'b0; t_valid = 1'b0;
    #1;
    check("rst2_vld", 64'(o_valid), 64'(0));
    check("rst2_s", 64'(o_s), 64'(0));
    check("rst2_c", 64'(o_c), 64'(0));
    check("rst2_ovf", 64'(o_ovf), 64'(0));
    sbq.delete();
    repeat (10) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // WIDTH=16, SEG=16: single register level.
    sel = 1;
    run_op("w16_ripple", 34'hFFFF, 34'd1, 1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
    run_op("w16_ovf_pos", 34'h7FFF, 34'd1, 1'b0, 1'b0, 34'h8000, 1'b0, 1'b1);
    run_op("w16_ovf_neg", 34'h8000, 34'h8000, 1'b0, 1'b0, 34'h0, 1'b1, 1'b1);

    // WIDTH=17, SEG=4: 1-bit partial last segment.
    sel = 2;
    run_op("w17_ripple", 34'h1_FFFF, 34'd1, 1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
    run_op("w17_ovf_pos", 34'hFFFF, 34'd1, 1'b0, 1'b0, 34'h1_0000, 1'b0, 1'b1);
    run_op("w17_ovf_neg", 34'h1_0000, 34'h1_0000, 1'b0, 1'b0, 34'h0, 1'b1, 1'b1);
    run_op("w17_sub_neg", 34'd5, 34'd7, 1'b0, 1'b1, 34'h1_FFFE, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
